// File: rtl/seqdet_pkg.sv
// Shared types and default sizes for the serial pattern detector.
// Pure declarations: no logic, no latency, no flow control.
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seqdet_hist.sv
// History shift register, fill counter and masked compare; hit is combinational from hist and in_bit.
// No backpressure: shifts only when told to, clear wins over shift.
module seqdet_hist
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic               in_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic [LEN_W-1:0]   fill,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_m1;

  // Oldest history bit drops off; only the low len bits ever take part in a compare.
  assign window = MAX_LEN'({hist, in_bit});
  assign len_m1 = len - LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = (((window ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= window;
      if (fill != len_m1) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector; match is a registered pulse one cycle after the completing bit.
// in_valid qualifies each bit, no backpressure; match_cnt exists only when SEQDET_CNT_EN is defined.
module seq_pattern_detector
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               armed,
  output logic               cfg_err
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [LEN_W-1:0]   fill;
  logic               hit;
  logic               cfg_ok;
  logic               sample;
  logic               match_nxt;
  logic               hist_clr;
  logic               hist_shift;
  logic               fill_last;

  assign cfg_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  // A bit presented alongside cfg_load belongs to the old configuration and is dropped.
  assign sample     = in_valid && (state != IDLE) && !cfg_load;
  assign match_nxt  = sample && (state == HUNT) && hit;
  assign hist_clr   = (cfg_load && cfg_ok) || (match_nxt && !ovl_q);
  assign hist_shift = sample && !hist_clr;
  assign fill_last  = ((fill + LEN_W'(1)) == (len_q - LEN_W'(1)));

  seqdet_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (hist_clr),
    .shift   (hist_shift),
    .in_bit  (in_bit),
    .pattern (pat_q),
    .len     (len_q),
    .fill    (fill),
    .hit     (hit)
  );

  always_comb begin
    state_nxt = state;
    if (cfg_load) begin
      if (!cfg_ok) begin
        state_nxt = IDLE;
      end else if (cfg_len == LEN_W'(1)) begin
        state_nxt = HUNT;
      end else begin
        state_nxt = FILL;
      end
    end else if (sample) begin
      case (state)
        FILL: if (fill_last) state_nxt = HUNT;
        HUNT: if (match_nxt && !ovl_q && (len_q != LEN_W'(1))) state_nxt = FILL;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      cfg_err <= 1'b0;
      match   <= 1'b0;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
      if (cfg_load) begin
        if (cfg_ok) begin
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          ovl_q   <= cfg_overlap;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  assign armed = (state != IDLE);

`ifdef SEQDET_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cfg_load) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= CNT_W'(match_nxt);
    end else if (match_nxt && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector (MAX_LEN=8, CNT_W=2); counter checks need SEQDET_CNT_EN.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       match;
  logic       armed;
  logic       cfg_err;
`ifdef SEQDET_CNT_EN
  logic [1:0] match_cnt;
`endif

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN (8),
    .CNT_W   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .armed       (armed),
    .cfg_err     (cfg_err)
`ifdef SEQDET_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  task automatic drive(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    in_valid    = 1'b0;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    logic bits [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    #12;
    nchk++; if (match !== 1'b0) begin nfail++; $display("FAIL reset match: got %b want 0", match); end
    nchk++; if (armed !== 1'b0) begin nfail++; $display("FAIL reset armed: got %b want 0", armed); end
    nchk++; if (cfg_err !== 1'b0) begin nfail++; $display("FAIL reset cfg_err: got %b want 0", cfg_err); end
`ifdef SEQDET_CNT_EN
    nchk++; if (match_cnt !== 2'd0) begin nfail++; $display("FAIL reset match_cnt: got %0d want 0", match_cnt); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bits[i]);
      nchk++; if (match !== 1'b0) begin nfail++; $display("FAIL unconfigured match bit%0d: got %b want 0", i, match); end
      nchk++; if (armed !== 1'b0) begin nfail++; $display("FAIL unconfigured armed bit%0d: got %b want 0", i, armed); end
    end
  endtask

  task automatic test_overlap();
    logic bits [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    // Upper pattern bits are junk and must not take part in the compare.
    load(8'hF3, 4'd2, 1'b1);
    nchk++; if (armed !== 1'b1) begin nfail++; $display("FAIL overlap armed: got %b want 1", armed); end
    nchk++; if (cfg_err !== 1'b0) begin nfail++; $display("FAIL overlap cfg_err: got %b want 0", cfg_err); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bits[i]);
      nchk++; if (match !== exp[i]) begin nfail++; $display("FAIL overlap bit%0d: match %b want %b", i + 1, match, exp[i]); end
    end
  endtask

  task automatic test_nonoverlap();
    logic exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    load(8'h03, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      nchk++; if (match !== exp[i]) begin nfail++; $display("FAIL nonoverlap bit%0d: match %b want %b", i + 1, match, exp[i]); end
    end
  endtask

  task automatic test_gaps();
    logic v   [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic b   [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load(8'b0000_1011, 4'd4, 1'b1);
    for (int i = 0; i < 11; i++) begin
      drive(v[i], b[i]);
      nchk++; if (match !== exp[i]) begin nfail++; $display("FAIL gaps step%0d: match %b want %b", i, match, exp[i]); end
    end
  endtask

  task automatic test_cfg_err();
    load(8'h01, 4'd0, 1'b0);
    nchk++; if (cfg_err !== 1'b1) begin nfail++; $display("FAIL len0 cfg_err: got %b want 1", cfg_err); end
    nchk++; if (armed !== 1'b0) begin nfail++; $display("FAIL len0 armed: got %b want 0", armed); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1);
      nchk++; if (match !== 1'b0) begin nfail++; $display("FAIL len0 match bit%0d: got %b want 0", i, match); end
    end
    load(8'h01, 4'd9, 1'b0);
    nchk++; if (cfg_err !== 1'b1) begin nfail++; $display("FAIL len9 cfg_err: got %b want 1", cfg_err); end
    nchk++; if (armed !== 1'b0) begin nfail++; $display("FAIL len9 armed: got %b want 0", armed); end
    load(8'h01, 4'd1, 1'b0);
    nchk++; if (cfg_err !== 1'b0) begin nfail++; $display("FAIL legal reload cfg_err: got %b want 0", cfg_err); end
    nchk++; if (armed !== 1'b1) begin nfail++; $display("FAIL legal reload armed: got %b want 1", armed); end
  endtask

  task automatic test_back_to_back();
    logic bits [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    cfg_load = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    nchk++; if (match !== 1'b0) begin nfail++; $display("FAIL bit with cfg_load: match %b want 0", match); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bits[i]);
      nchk++; if (match !== bits[i]) begin nfail++; $display("FAIL len1 b2b bit%0d: match %b want %b", i, match, bits[i]); end
    end
  endtask

`ifdef SEQDET_CNT_EN
  task automatic test_counter();
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load(8'h01, 4'd1, 1'b1);
    nchk++; if (match_cnt !== 2'd0) begin nfail++; $display("FAIL cnt after load: got %0d want 0", match_cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      nchk++; if (match_cnt !== exp[i]) begin nfail++; $display("FAIL cnt match%0d: got %0d want %0d", i + 1, match_cnt, exp[i]); end
    end
    cnt_clr = 1'b1;
    drive(1'b1, 1'b1);
    cnt_clr = 1'b0;
    nchk++; if (match_cnt !== 2'd1) begin nfail++; $display("FAIL cnt_clr with match: got %0d want 1", match_cnt); end
    nchk++; if (match !== 1'b1) begin nfail++; $display("FAIL match under cnt_clr: got %b want 1", match); end
    cnt_clr = 1'b1;
    drive(1'b0, 1'b0);
    cnt_clr = 1'b0;
    nchk++; if (match_cnt !== 2'd0) begin nfail++; $display("FAIL cnt_clr alone: got %0d want 0", match_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    load(8'h01, 4'd0, 1'b0);
    nchk++; if (cfg_err !== 1'b1) begin nfail++; $display("FAIL pre-reset cfg_err: got %b want 1", cfg_err); end
    #2; rst_n = 1'b0; #1;
    nchk++; if (cfg_err !== 1'b0) begin nfail++; $display("FAIL mid reset cfg_err: got %b want 0", cfg_err); end
    @(posedge clk); #1; rst_n = 1'b1;
    load(8'h01, 4'd1, 1'b1);
    drive(1'b1, 1'b1);
    nchk++; if (match !== 1'b1) begin nfail++; $display("FAIL pre-reset match: got %b want 1", match); end
    #2; rst_n = 1'b0; #1;
    nchk++; if (match !== 1'b0) begin nfail++; $display("FAIL mid reset match: got %b want 0", match); end
    nchk++; if (armed !== 1'b0) begin nfail++; $display("FAIL mid reset armed: got %b want 0", armed); end
`ifdef SEQDET_CNT_EN
    nchk++; if (match_cnt !== 2'd0) begin nfail++; $display("FAIL mid reset match_cnt: got %0d want 0", match_cnt); end
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      nchk++; if (match !== 1'b0 || armed !== 1'b0) begin
        nfail++; $display("FAIL post-reset idle bit%0d: match %b armed %b want 0 0", i, match, armed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_cfg_err();
    test_back_to_back();
`ifdef SEQDET_CNT_EN
    test_counter();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
